// File: rtl/multiplier_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multiplier_sequencer (with base_multiplier slice)
// Description : Digit-serial unsigned WIDTH x WIDTH multiplier, one b-digit/cycle
// Revision    : 1.0
// ============================================================================

module base_multiplier #(
    parameter int BASE_WIDTH = 4
) (
    input  logic [BASE_WIDTH-1:0]   a_i,
    input  logic [BASE_WIDTH-1:0]   b_i,
    output logic [2*BASE_WIDTH-1:0] p_o
);
    assign p_o = {{BASE_WIDTH{1'b0}}, a_i} * {{BASE_WIDTH{1'b0}}, b_i};
endmodule

module multiplier_sequencer #(
    parameter int WIDTH      = 32,
    parameter int BASE_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 kill,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     req_a,
    input  logic [WIDTH-1:0]     req_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [2*WIDTH-1:0]   resp_result,
    output logic                 busy
);
    localparam int STEPS = WIDTH / BASE_WIDTH;
    localparam int SW    = $clog2(STEPS + 1);
    localparam int PW    = WIDTH + BASE_WIDTH;
    localparam int AW    = 2 * WIDTH;

    if ((WIDTH % BASE_WIDTH) != 0 || BASE_WIDTH > 4) begin : g_width_check
        $fatal(1, "\033[31mmultiplier_sequencer: WIDTH must be a multiple of BASE_WIDTH (<= 4)\033[0m");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     step_q, step_d;
    logic [SW-1:0]     pstep_q, pstep_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     partial_q, partial_d;

    logic [BASE_WIDTH-1:0]   w_digit;
    logic [2*BASE_WIDTH-1:0] w_prod [STEPS];
    logic [PW-1:0]           w_partial;
    logic [AW-1:0]           w_shifted;

    // Past the last digit the shift empties b, so the drain cycle multiplies by zero.
    assign w_digit = BASE_WIDTH'(b_q >> (step_q * BASE_WIDTH));

    for (genvar k = 0; k < STEPS; k++) begin : g_slices
        base_multiplier #(
            .BASE_WIDTH (BASE_WIDTH)
        ) u_slice (
            .a_i (a_q[k*BASE_WIDTH +: BASE_WIDTH]),
            .b_i (w_digit),
            .p_o (w_prod[k])
        );
    end

    always_comb begin
        w_partial = '0;
        for (int k = 0; k < STEPS; k++) begin
            w_partial = w_partial + (PW'(w_prod[k]) << (k * BASE_WIDTH));
        end
    end

    // The partial product is registered, so accumulation trails the digit by one cycle.
    assign w_shifted = AW'(partial_q) << (pstep_q * BASE_WIDTH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            pstep_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            partial_q <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            pstep_q   <= pstep_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            partial_q <= partial_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        pstep_d   = pstep_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        partial_d = partial_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && !kill) begin
                    state_d   = S_RUN;
                    a_d       = req_a;
                    b_d       = req_b;
                    acc_d     = '0;
                    step_d    = '0;
                    pstep_d   = '0;
                    partial_d = '0;
                end
            end
            S_RUN: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d     = acc_q + w_shifted;
                    partial_d = w_partial;
                    pstep_d   = step_q;
                    step_d    = step_q + SW'(1);
                    if (step_q == SW'(STEPS)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (kill || resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready   = (state_q == S_IDLE) && !kill;
    assign resp_valid  = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign resp_result = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_multiplier_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiplier_sequencer
// Description : Directed and back-to-back checks of the multiplier sequencer
// Revision    : 1.0
// ============================================================================
module tb_multiplier_sequencer;
    logic        clk;
    logic        reset;
    logic        kill;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_result;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    multiplier_sequencer #(
        .WIDTH      (32),
        .BASE_WIDTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .kill        (kill),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold the request until accepted; returns just after the accept edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (!resp_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        n_checks++;
        if (resp_result !== 64'd0) begin n_fail++; $display("FAIL reset_acc: got %h expected 0", resp_result); end
    endtask

    task automatic test_basic();
        int lat;
        resp_ready = 1'b1;
        issue(32'd3, 32'd5);
        n_checks++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_drop: got %b expected 0", req_ready); end
        wait_resp(lat);
        n_checks++;
        if (lat !== 9) begin n_fail++; $display("FAIL basic_latency: got %0d expected 9", lat); end
        n_checks++;
        if (resp_result !== 64'd15) begin n_fail++; $display("FAIL basic_result: got %h expected %h", resp_result, 64'd15); end
        tick();
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_after_hs: got ready=%b busy=%b expected ready=1 busy=0", req_ready, busy);
        end
    endtask

    task automatic test_products();
        logic [31:0] ta [3] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000};
        logic [31:0] tb [3] = '{32'hFFFF_FFFF, 32'h9ABC_DEF0, 32'hDEAD_BEEF};
        logic [63:0] te [3] = '{64'hFFFF_FFFE_0000_0001, 64'h0B00_EA4E_242D_2080, 64'h0};
        int lat;
        resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(ta[i], tb[i]);
            wait_resp(lat);
            n_checks++;
            if (lat !== 9) begin n_fail++; $display("FAIL product%0d_latency: got %0d expected 9", i, lat); end
            n_checks++;
            if (resp_result !== te[i]) begin
                n_fail++; $display("FAIL product%0d_result: got %h expected %h", i, resp_result, te[i]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        resp_ready = 1'b0;
        issue(32'd2, 32'd3);
        wait_resp(lat);
        n_checks++;
        if (lat !== 9 || resp_result !== 64'd6) begin
            n_fail++; $display("FAIL bp_first: got lat=%0d result=%h expected lat=9 result=6", lat, resp_result);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (resp_valid !== 1'b1 || resp_result !== 64'd6 || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got valid=%b result=%h ready=%b expected 1/6/0", i, resp_valid, resp_result, req_ready);
            end
        end
        resp_ready = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_release: got busy=%b ready=%b valid=%b expected 0/1/0", busy, req_ready, resp_valid);
        end
    endtask

    task automatic test_kill();
        int lat;
        int seen = 0;
        resp_ready = 1'b1;
        issue(32'hDEAD_BEEF, 32'hCAFE_F00D);
        repeat (4) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL kill_idle: got busy=%b valid=%b expected 0/0", busy, resp_valid);
        end
        for (int i = 0; i < 12; i++) begin
            if (resp_valid) seen++;
            tick();
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL kill_no_resp: got %0d valid cycles expected 0", seen); end
        issue(32'd7, 32'd6);
        wait_resp(lat);
        n_checks++;
        if (lat !== 9 || resp_result !== 64'd42) begin
            n_fail++; $display("FAIL kill_next: got lat=%0d result=%h expected lat=9 result=2a", lat, resp_result);
        end
        tick();
    endtask

    task automatic test_reset_midop();
        int lat;
        resp_ready = 1'b1;
        issue(32'd5, 32'd5);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_run: got valid=%b busy=%b ready=%b expected 0/0/1", resp_valid, busy, req_ready);
        end
        resp_ready = 1'b0;
        issue(32'd5, 32'd5);
        wait_resp(lat);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        resp_ready = 1'b1;
        n_checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_done: got valid=%b busy=%b ready=%b expected 0/0/1", resp_valid, busy, req_ready);
        end
    endtask

    task automatic test_kill_idle();
        int lat;
        resp_ready = 1'b1;
        kill      = 1'b1;
        req_a     = 32'd4;
        req_b     = 32'd4;
        req_valid = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL killidle_ready: got %b expected 0", req_ready); end
        repeat (3) tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL killidle_accept: got busy=%b expected 0", busy); end
        kill = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL killidle_release: got %b expected 1", req_ready); end
        tick();
        req_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL killidle_start: got busy=%b expected 1", busy); end
        wait_resp(lat);
        n_checks++;
        if (lat !== 9 || resp_result !== 64'd16) begin
            n_fail++; $display("FAIL killidle_result: got lat=%0d result=%h expected lat=9 result=10", lat, resp_result);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [20];
        logic [31:0] vb [20];
        logic [63:0] exp_q [$];
        logic [63:0] e;
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        for (int i = 0; i < 20; i++) begin
            va[i] = $urandom;
            vb[i] = $urandom;
        end
        va[0] = 32'hFFFF_FFFF;
        vb[0] = 32'h8000_0001;
        while (got < 20 && cyc < 3000) begin
            req_valid  = (sent < 20);
            req_a      = (sent < 20) ? va[sent] : 32'd0;
            req_b      = (sent < 20) ? vb[sent] : 32'd0;
            resp_ready = 1'($urandom_range(0, 1));
            #1;
            if (req_valid && req_ready) begin
                n_checks++;
                if (exp_q.size() !== 0) begin
                    n_fail++; $display("FAIL b2b_outstanding: got %0d pending at accept expected 0", exp_q.size());
                end
                exp_q.push_back({32'd0, va[sent]} * {32'd0, vb[sent]});
                sent++;
            end
            if (resp_valid && resp_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
                n_checks++;
                if (resp_result !== e) begin
                    n_fail++; $display("FAIL b2b_result%0d: got %h expected %h", got, resp_result, e);
                end
                got++;
            end
            tick();
            cyc++;
        end
        req_valid = 1'b0;
        n_checks++;
        if (got !== 20) begin n_fail++; $display("FAIL b2b_count: got %0d responses expected 20", got); end
    endtask

    initial begin
        reset      = 1'b1;
        kill       = 1'b0;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        test_reset();
        test_basic();
        test_products();
        test_backpressure();
        test_kill();
        test_reset_midop();
        test_kill_idle();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
